// File: rtl/enum_frame_decoder.sv
// enum_frame_decoder
//   Consumer stage downstream of the enum-constant driver. Accepts a frame
//   of four enum-coded fields over valid/ready. Each field is decoded to a
//   1-bit symbol plus an illegal-code flag. Decoded frames are buffered in a
//   2-entry FIFO. Intake halts after ERR_LIMIT consecutive erroneous frames.
//   Saturating statistics count accepted frames and erroneous frames.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clear               sync pulse: leave HALT, zero statistics and consec count
//   in_valid/in_ready   input handshake; accept when both are high
//   in_var1..in_var4    5/6/7/8-bit coded fields
//   out_valid/out_ready FIFO head valid / downstream pop
//   out_sym, out_err    decoded symbols / illegal flags, bit i = field i+1
//   frame_cnt, err_cnt  saturating accepted-frame / erroneous-frame counters
//   halted              intake halted after an error run
module enum_frame_decoder #(
  parameter logic [4:0]  E1_A      = 5'b00111,
  parameter logic [4:0]  E1_B      = 5'b11100,
  parameter logic [5:0]  E2_A      = 6'b000111,
  parameter logic [5:0]  E2_B      = 6'b111000,
  parameter logic [6:0]  E3_A      = 7'b0011100,
  parameter logic [6:0]  E3_B      = 7'b1100011,
  parameter logic [7:0]  E4_A      = 8'b01011010,
  parameter logic [7:0]  E4_B      = 8'b11010011,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_var1,
  input  logic [5:0]       in_var2,
  input  logic [6:0]       in_var3,
  input  logic [7:0]       in_var4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_sym,
  output logic [3:0]       out_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             halted
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [3:0]       LIMIT   = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       consec_q, consec_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       mem_q [2];
  logic [7:0]       mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [3:0]       dec_sym;
  logic [3:0]       dec_err;
  logic             accept;
  logic             pop;

  // Field decode: A -> 0, B -> 1, anything else -> sym 0 with error flag.
  always_comb begin
    dec_sym = '0;
    dec_err = '0;
    dec_sym[0] = (in_var1 == E1_B);
    dec_err[0] = (in_var1 != E1_A) && (in_var1 != E1_B);
    dec_sym[1] = (in_var2 == E2_B);
    dec_err[1] = (in_var2 != E2_A) && (in_var2 != E2_B);
    dec_sym[2] = (in_var3 == E3_B);
    dec_err[2] = (in_var3 != E3_A) && (in_var3 != E3_B);
    dec_sym[3] = (in_var4 == E4_B);
    dec_err[3] = (in_var4 != E4_A) && (in_var4 != E4_B);
  end

  // Fullness uses the registered count only, so a same-cycle pop never
  // makes room for a push when full.
  assign in_ready  = (count_q != 2'd2) && (state_q == S_RUN) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  assign out_sym   = mem_q[rd_ptr_q][3:0];
  assign out_err   = mem_q[rd_ptr_q][7:4];
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign halted    = (state_q == S_HALT);

  always_comb begin
    state_d     = state_q;
    consec_d    = consec_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    // FIFO datapath (clear leaves contents untouched)
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (accept) begin
      mem_d[wr_ptr_q] = {dec_err, dec_sym};
      wr_ptr_d        = ~wr_ptr_q;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Statistics and error-run tracking. accept is never high with clear.
    if (clear) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      consec_d    = '0;
      state_d     = S_RUN;
    end else if (accept) begin
      if (frame_cnt_q != CNT_MAX) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      if (|dec_err) begin
        if (err_cnt_q != CNT_MAX) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        consec_d = consec_q + 4'd1;
      end else begin
        consec_d = '0;
      end
      // The frame that completes the run is still queued and counted.
      if (consec_d == LIMIT) begin
        state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      consec_q    <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

endmodule
